// File: rtl/seg_serial_tx.sv
// seg_serial_tx: serial transmitter for the 8-digit seven-segment board.
// Accepts a 64-bit segment frame over a valid/ready handshake. It shifts the
// frame MSB-first into the 74HC595 chain on SEGCLK/SEGOUT, then strobes SEGEN
// to latch it.
//
// Optional feature: define SEG_SKIP_SAME_EN to skip re-sending a frame that
// is identical to the last completed one.
//
// Ports:
//   clk          system clock
//   RSTN         synchronous active-low reset
//   frame_valid  sender has a frame on frame_data
//   frame_data   64-bit segment frame, bit 63 shifted first
//   frame_ready  block can accept a frame (IDLE only)
//   SEGCLK       shift clock to the chain
//   SEGOUT       serial data, stable while SEGCLK is high
//   SEGEN        latch strobe, active-high, one CLK_DIV-wide pulse per frame
//   SEGCLR       chain clear, active-low
//   busy         high in any state other than IDLE and CLR
//   frame_done   one-cycle pulse on the last cycle of LATCH (or of SKIP)
module seg_serial_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CLR_CYC = 16
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        frame_valid,
    input  logic [63:0] frame_data,
    output logic        frame_ready,
    output logic        SEGCLK,
    output logic        SEGOUT,
    output logic        SEGEN,
    output logic        SEGCLR,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned FRAME_W = 64;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 6;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_SKIP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] shift_q, shift_d;

    logic seg_clk_q, seg_clk_d;
    logic seg_out_q, seg_out_d;
    logic seg_en_q, seg_en_d;
    logic seg_clr_q, seg_clr_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

`ifdef SEG_SKIP_SAME_EN
    logic [FRAME_W-1:0] last_frame_q, last_frame_d;
    logic               last_valid_q, last_valid_d;
`endif

    // Next-state, counters and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef SEG_SKIP_SAME_EN
        last_frame_d = last_frame_q;
        last_valid_d = last_valid_q;
`endif

        unique case (state_q)
            ST_CLR: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (frame_valid && ready_q) begin
                    cnt_d = CNT_W'(CLK_DIV - 1);
`ifdef SEG_SKIP_SAME_EN
                    if (last_valid_q && (frame_data == last_frame_q)) begin
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        shift_d = frame_data;
                        bit_d   = '0;
                    end
`else
                    state_d = ST_SHIFT_LO;
                    shift_d = frame_data;
                    bit_d   = '0;
`endif
                end
            end
            ST_SHIFT_LO: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT_HI;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_q == '0) begin
                    // Rotate so that the original frame is back in place after 64 bits
                    shift_d = {shift_q[FRAME_W-2:0], shift_q[FRAME_W-1]};
                    bit_d   = bit_q + BIT_W'(1);
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    state_d = (bit_q == BIT_W'(FRAME_W - 1)) ? ST_LATCH : ST_SHIFT_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
`ifdef SEG_SKIP_SAME_EN
                    last_frame_d = shift_q;
                    last_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SKIP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLR;
                cnt_d   = CNT_W'(CLR_CYC);
            end
        endcase

        // Outputs are a function of the next state so they register cleanly
        seg_clk_d = (state_d == ST_SHIFT_HI);
        seg_out_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ?
                    shift_d[FRAME_W-1] : 1'b0;
        seg_en_d  = (state_d == ST_LATCH);
        seg_clr_d = (state_d != ST_CLR);
        ready_d   = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_CLR);
        done_d    = ((state_d == ST_LATCH) && (cnt_d == '0)) || (state_d == ST_SKIP);
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q   <= ST_CLR;
            cnt_q     <= CNT_W'(CLR_CYC);
            bit_q     <= '0;
            shift_q   <= '0;
            seg_clk_q <= 1'b0;
            seg_out_q <= 1'b0;
            seg_en_q  <= 1'b0;
            seg_clr_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEG_SKIP_SAME_EN
            last_frame_q <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            seg_clk_q <= seg_clk_d;
            seg_out_q <= seg_out_d;
            seg_en_q  <= seg_en_d;
            seg_clr_q <= seg_clr_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEG_SKIP_SAME_EN
            last_frame_q <= last_frame_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign frame_ready = ready_q;
    assign SEGCLK      = seg_clk_q;
    assign SEGOUT      = seg_out_q;
    assign SEGEN       = seg_en_q;
    assign SEGCLR      = seg_clr_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_seg_serial_tx.sv
// Directed bench for seg_serial_tx with CLK_DIV=4, CLR_CYC=16.
module tb_seg_serial_tx;

    logic        clk;
    logic        RSTN;
    logic        frame_valid;
    logic [63:0] frame_data;
    logic        frame_ready;
    logic        SEGCLK;
    logic        SEGOUT;
    logic        SEGEN;
    logic        SEGCLR;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    seg_serial_tx #(.CLK_DIV(4), .CLR_CYC(16)) dut (
        .clk         (clk),
        .RSTN        (RSTN),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .SEGCLK      (SEGCLK),
        .SEGOUT      (SEGOUT),
        .SEGEN       (SEGEN),
        .SEGCLR      (SEGCLR),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After reset release: count cycles SEGCLR stays low, then check IDLE outputs
    task automatic wait_clr(input string tag);
        int n;
        int en;
        n  = 0;
        en = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (SEGEN) en++;
            if (SEGCLR) break;
            n++;
        end
        check({tag, "/clr_low_cycles"}, 64'(n), 64'd16);
        check({tag, "/ready_busy_clk_en"}, {60'd0, frame_ready, busy, SEGCLK, SEGEN}, 64'b1000);
        check({tag, "/segen_during_clr"}, 64'(en), 64'd0);
    endtask

    // Called just before the handshake edge with frame_valid high and frame_ready high
    task automatic xfer(input string tag, input logic [63:0] exp,
                        input logic [63:0] next_data, input logic keep_valid);
        int rises, en_cyc, done_k, done_n, ready_k;
        logic prev;
        logic [63:0] rx;
        step();
        check({tag, "/first_out_clk_busy_rdy"}, {60'd0, SEGOUT, SEGCLK, busy, frame_ready},
              {60'd0, exp[63], 1'b0, 1'b1, 1'b0});
        frame_data  = next_data;
        frame_valid = keep_valid;
        rises = 0; en_cyc = 0; done_k = 0; done_n = 0; ready_k = 0;
        prev = 1'b0;
        rx = '0;
        for (int k = 1; k <= 2000; k++) begin
            if (k > 1) step();
            if (SEGCLK && !prev) begin
                rises++;
                rx = {rx[62:0], SEGOUT};
            end
            prev = SEGCLK;
            if (SEGEN) en_cyc++;
            if (frame_done) begin
                done_k = k;
                done_n++;
            end
            if (frame_ready) begin
                ready_k = k;
                break;
            end
        end
        check({tag, "/segclk_rises"}, 64'(rises), 64'd64);
        check({tag, "/rx_data"}, rx, exp);
        check({tag, "/segen_cycles"}, 64'(en_cyc), 64'd4);
        check({tag, "/done_cycle"}, 64'(done_k), 64'd516);
        check({tag, "/done_pulses"}, 64'(done_n), 64'd1);
        check({tag, "/ready_cycle"}, 64'(ready_k), 64'd517);
    endtask

    initial begin
        int rises;
        int en;
        logic prev;
        logic [63:0] same;

        RSTN        = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        step();
        step();
        step();
        check("reset_outputs", {57'd0, SEGCLK, SEGOUT, SEGEN, SEGCLR, frame_ready, busy, frame_done}, 64'd0);

        RSTN = 1'b1;
        wait_clr("por");

        // Frame 1 with sender swapping data and holding valid mid-transfer
        frame_data  = 64'h8000_0000_0000_0001;
        frame_valid = 1'b1;
        xfer("f1", 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        // Held valid is accepted on the edge right after ready returns
        xfer("f2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        check("idle_after_f2", {61'd0, busy, SEGCLK, SEGEN}, 64'd0);

        // Abort around bit 30
        frame_data  = 64'hA5A5_A5A5_A5A5_A5A5;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        rises = 0;
        en    = 0;
        prev  = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (SEGEN) en++;
            if (SEGCLK && !prev) rises++;
            prev = SEGCLK;
            if (rises == 30) break;
            step();
        end
        check("abort_reached_bit30", 64'(rises), 64'd30);
        RSTN = 1'b0;
        step();
        if (SEGEN) en++;
        check("abort_reset_outputs", {57'd0, SEGCLK, SEGOUT, SEGEN, SEGCLR, frame_ready, busy, frame_done}, 64'd0);
        step();
        if (SEGEN) en++;
        step();
        if (SEGEN) en++;
        RSTN = 1'b1;
        wait_clr("abort");
        check("abort_no_segen", 64'(en), 64'd0);

        same = 64'h1234_5678_9ABC_DEF0;
        frame_data  = same;
        frame_valid = 1'b1;
        xfer("s1", same, same, 1'b0);
`ifdef SEG_SKIP_SAME_EN
        // Identical frame: skipped, done on the next cycle
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check("skip_done_clk_en_rdy_busy", {59'd0, frame_done, SEGCLK, SEGEN, frame_ready, busy}, 64'b10001);
        step();
        check("skip_after_done_clk_en_rdy", {60'd0, frame_done, SEGCLK, SEGEN, frame_ready}, 64'b0001);
        // Reset forgets the last frame, so it is shifted again
        RSTN = 1'b0;
        step();
        step();
        RSTN = 1'b1;
        wait_clr("skip_rst");
        frame_data  = same;
        frame_valid = 1'b1;
        xfer("s3", same, same, 1'b0);
`else
        // Without the skip feature an identical frame is fully resent
        frame_valid = 1'b1;
        xfer("s2", same, same, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
